// File: rtl/ov7670_sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB target model.
package ov7670_sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } sccb_state_t;

  localparam logic [6:0] OV7670_SCCB_ID = 7'h21;
  localparam logic       SCCB_WRITE     = 1'b0;
  localparam logic       SCCB_READ      = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Idle bus is high, so reset the chains high to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (reset_) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    scl_s     = scl_sync[SYNC_STAGES-1];
    sda_s     = sda_sync[SYNC_STAGES-1];
    scl_rise  = scl_s & ~scl_q;
    scl_fall  = ~scl_s & scl_q;
    start_det = scl_s & scl_q & sda_q & ~sda_s;
    stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  end

endmodule

// File: rtl/ov7670_sccb_responder.sv
// SCCB target for the OV7670: decodes ID/sub-address/data phases over a 256x8 register file
// and drives SDA open-drain for ACK and read data.
module ov7670_sccb_responder
  import ov7670_sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = OV7670_SCCB_ID,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          AUTO_INC    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .reset_   (reset_),
    .scl      (scl),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  sccb_state_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        rw_q, rw_d;
  logic        wr_pend_q, wr_pend_d;
  logic        rd_valid_q, rd_valid_d;
  logic        reload_q, reload_d;
  logic [7:0]  regfile [256];
  logic [7:0]  dbg_data_q;
  logic [7:0]  byte_in;
  logic [7:0]  rd_byte;

  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= SCCB_WRITE;
      wr_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      reload_q   <= 1'b0;
      dbg_data_q <= '0;
      regfile    <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      wr_pend_q  <= wr_pend_d;
      rd_valid_q <= rd_valid_d;
      reload_q   <= reload_d;
      dbg_data_q <= regfile[dbg_addr];
      if (wr_pend_q) regfile[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    wr_pend_d  = 1'b0;
    rd_valid_d = 1'b0;
    reload_d   = reload_q;
    byte_in    = {shift_q[6:0], sda_s};
    rd_byte    = regfile[ptr_q];

    // The committed write uses ptr_q this cycle; advance afterwards.
    if (wr_pend_q && AUTO_INC) ptr_d = ptr_q + 8'd1;

    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      reload_d = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      reload_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StSub, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                if (byte_in[7:1] == DEV_ID) begin
                  state_d = StAddrAck;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StSub) begin
                ptr_d   = byte_in;
                state_d = StSubAck;
              end else begin
                wr_pend_d = 1'b1;
                state_d   = StWdataAck;
              end
            end
          end
        end
        // First fall asserts ACK, second fall ends it.
        StAddrAck, StSubAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == StAddrAck && rw_q == SCCB_READ) begin
                shift_d   = rd_byte;
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = '0;
                state_d   = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StSub;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d   = 1'b0;
              rd_valid_d = 1'b1;
              state_d    = StRdataAck;
              if (AUTO_INC) ptr_d = ptr_q + 8'd1;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (sda_s) state_d = StIgnore;
            else       reload_d = 1'b1;
          end else if (scl_fall && reload_q) begin
            reload_d  = 1'b0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = StRdata;
          end
        end
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sda_oe   = sda_oe_q & ~reset_;
    wr_valid = wr_pend_q;
    wr_addr  = ptr_q;
    wr_data  = shift_q;
    rd_valid = rd_valid_q;
    busy     = (state_q != StIdle);
    dbg_data = dbg_data_q;
  end

endmodule

// File: tb/tb_ov7670_sccb_responder.sv
// Directed bench: bit-banged SCCB master on a wired-AND bus shared by two responders.
module tb_ov7670_sccb_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_, scl, sda_m, sda_w;
  logic [7:0] dbg_addr;
  logic       sda_oe0, wr_valid0, rd_valid0, busy0;
  logic [7:0] wr_addr0, wr_data0, dbg_data0;
  logic       sda_oe1, wr_valid1, rd_valid1, busy1;
  logic [7:0] wr_addr1, wr_data1, dbg_data1;

  assign sda_w = sda_m & ~sda_oe0 & ~sda_oe1;

  ov7670_sccb_responder #(.DEV_ID(7'h21), .SYNC_STAGES(2), .AUTO_INC(1'b0)) dut0 (
    .clk(clk), .reset_(reset_), .scl(scl), .sda_in(sda_w), .sda_oe(sda_oe0),
    .wr_valid(wr_valid0), .wr_addr(wr_addr0), .wr_data(wr_data0), .rd_valid(rd_valid0),
    .busy(busy0), .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  ov7670_sccb_responder #(.DEV_ID(7'h22), .SYNC_STAGES(2), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .reset_(reset_), .scl(scl), .sda_in(sda_w), .sda_oe(sda_oe1),
    .wr_valid(wr_valid1), .wr_addr(wr_addr1), .wr_data(wr_data1), .rd_valid(rd_valid1),
    .busy(busy1), .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  int          checks = 0;
  int          passed = 0;
  logic [15:0] exp_wr0[$];
  logic [15:0] exp_wr1[$];
  logic [7:0]  exp_rd[$];
  int          rd_cnt0 = 0;
  int          rd_cnt1 = 0;
  bit          oe_seen = 1'b0;
  logic [15:0] e0, e1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write scoreboards: every wr_valid must match the oldest expected (addr,data).
  always @(negedge clk) begin
    if (sda_oe0 || sda_oe1) oe_seen = 1'b1;
    if (rd_valid0) rd_cnt0++;
    if (rd_valid1) rd_cnt1++;
    if (wr_valid0) begin
      if (exp_wr0.size() > 0) e0 = exp_wr0.pop_front();
      else e0 = 'x;
      check("wr0", {wr_addr0, wr_data0}, e0);
    end
    if (wr_valid1) begin
      if (exp_wr1.size() > 0) e1 = exp_wr1.pop_front();
      else e1 = 'x;
      check("wr1", {wr_addr1, wr_data1}, e1);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    wait_clk(4); sda_m = b;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); s = sda_w;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic start_cond();
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); sda_m = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); sda_m = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nak, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nak, s);
  endtask

  task automatic send_ack(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    send_byte(b, a);
    check(tag, a, exp_ack);
  endtask

  task automatic write_reg(input logic [6:0] id, input logic [7:0] sub, input logic [7:0] data,
                           input string tag);
    start_cond();
    send_ack({id, 1'b0}, 1'b0, {tag, "_id_ack"});
    send_ack(sub, 1'b0, {tag, "_sub_ack"});
    if (id == 7'h21) exp_wr0.push_back({sub, data});
    else exp_wr1.push_back({sub, data});
    send_ack(data, 1'b0, {tag, "_data_ack"});
    stop_cond();
  endtask

  task automatic set_ptr(input logic [6:0] id, input logic [7:0] sub, input string tag);
    start_cond();
    send_ack({id, 1'b0}, 1'b0, {tag, "_id_ack"});
    send_ack(sub, 1'b0, {tag, "_sub_ack"});
    stop_cond();
  endtask

  task automatic read_tx(input logic [6:0] id, input int n, input string tag);
    logic [7:0] b, e;
    start_cond();
    send_ack({id, 1'b1}, 1'b0, {tag, "_id_ack"});
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      if (exp_rd.size() > 0) e = exp_rd.pop_front();
      else e = 'x;
      check({tag, "_data"}, b, e);
    end
    stop_cond();
  endtask

  task automatic dbg_check(input logic [7:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    wait_clk(2);
    check(tag, dbg_data0, exp);
  endtask

  initial begin
    int   rd_before;
    logic s;
    reset_   = 1'b1;
    scl      = 1'b1;
    sda_m    = 1'b1;
    dbg_addr = 8'h00;
    wait_clk(3);
    check("rst_sda_oe", sda_oe0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_wr_valid", wr_valid0, 1'b0);
    check("rst_rd_valid", rd_valid0, 1'b0);
    check("rst_dbg_data", dbg_data0, 8'h00);
    reset_ = 1'b0;
    wait_clk(4);

    // 1: three-phase write
    start_cond();
    check("t1_busy_after_start", busy0, 1'b1);
    send_ack(8'h42, 1'b0, "t1_id_ack");
    send_ack(8'h12, 1'b0, "t1_sub_ack");
    exp_wr0.push_back({8'h12, 8'h80});
    send_ack(8'h80, 1'b0, "t1_data_ack");
    stop_cond();
    check("t1_busy_after_stop", busy0, 1'b0);
    dbg_check(8'h12, 8'h80, "t1_dbg");

    // 2: foreign ID is never acknowledged
    oe_seen = 1'b0;
    start_cond();
    send_ack(8'h60, 1'b1, "t2_id_nak");
    send_ack(8'h12, 1'b1, "t2_sub_nak");
    send_ack(8'h55, 1'b1, "t2_data_nak");
    check("t2_busy_before_stop", busy0, 1'b1);
    stop_cond();
    check("t2_oe_never", oe_seen, 1'b0);
    check("t2_busy_after_stop", busy0, 1'b0);
    dbg_check(8'h12, 8'h80, "t2_dbg_unchanged");

    // 3: write, set pointer, read back with NAK
    write_reg(7'h21, 8'h3A, 8'hC4, "t3_wr");
    set_ptr(7'h21, 8'h3A, "t3_ptr");
    rd_before = rd_cnt0;
    exp_rd.push_back(8'hC4);
    read_tx(7'h21, 1, "t3_rd");
    check("t3_rd_valid_once", rd_cnt0 - rd_before, 1);
    check("t3_idle", busy0, 1'b0);

    // 4a: no auto-increment -> same byte twice
    exp_rd.push_back(8'hC4);
    exp_rd.push_back(8'hC4);
    read_tx(7'h21, 2, "t4_rd_noinc");

    // 4b: auto-increment wraps FF -> 00 on both write and read
    start_cond();
    send_ack(8'h44, 1'b0, "t4_inc_id_ack");
    send_ack(8'hFF, 1'b0, "t4_inc_sub_ack");
    exp_wr1.push_back({8'hFF, 8'hA5});
    send_ack(8'hA5, 1'b0, "t4_inc_d0_ack");
    exp_wr1.push_back({8'h00, 8'h5A});
    send_ack(8'h5A, 1'b0, "t4_inc_d1_ack");
    stop_cond();
    set_ptr(7'h22, 8'hFF, "t4_inc_ptr");
    rd_before = rd_cnt1;
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h5A);
    read_tx(7'h22, 2, "t4_rd_inc");
    check("t4_rd_valid_twice", rd_cnt1 - rd_before, 2);
    dbg_addr = 8'h00;
    wait_clk(2);
    check("t4_dbg1_wrap", dbg_data1, 8'h5A);
    check("t4_busy1", busy1, 1'b0);

    // 5: repeated START in the middle of a data byte discards it
    write_reg(7'h21, 8'h20, 8'h77, "t5_wr");
    start_cond();
    send_ack(8'h42, 1'b0, "t5_id_ack");
    send_ack(8'h20, 1'b0, "t5_sub_ack");
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    start_cond();
    send_ack(8'h42, 1'b0, "t5_rs_id_ack");
    send_ack(8'h20, 1'b0, "t5_rs_sub_ack");
    stop_cond();
    dbg_check(8'h20, 8'h77, "t5_dbg_unchanged");

    // 6: reset while ACK is being driven
    start_cond();
    for (int i = 7; i >= 0; i--) clk_bit(s ^ s ^ ((8'h42 >> i) & 8'h01) != 0, s);
    wait_clk(4);
    sda_m = 1'b1;
    check("t6_ack_driven", sda_oe0, 1'b1);
    reset_ = 1'b1;
    #1;
    check("t6_oe_release_now", sda_oe0, 1'b0);
    wait_clk(1);
    check("t6_busy_reset", busy0, 1'b0);
    check("t6_oe_after", sda_oe0, 1'b0);
    wait_clk(2);
    reset_ = 1'b0;
    wait_clk(4);
    stop_cond();
    dbg_check(8'h12, 8'h00, "t6_regfile_cleared");
    write_reg(7'h21, 8'h05, 8'h3C, "t6_wr");
    dbg_check(8'h05, 8'h3C, "t6_dbg");

    check("wr0_all_seen", exp_wr0.size(), 0);
    check("wr1_all_seen", exp_wr1.size(), 0);
    check("rd_all_seen", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
